gen_stream_arb_mux: RTL and testbench
=====================================

# gen_stream_arb_mux

Parametrised N-channel, W-bit stream multiplexer with valid/ready handshakes, packet locking and a registered output stage. The arbitration scheme (fixed priority or round-robin) is selected at elaboration by a generate-if on a parameter, generalising the two-input mux selector to many channels, arbitrary width and flow control. It sits between several packet sources and a single downstream consumer.

## Interface

- WIDTH, 8, data width per channel (>=1)
- CHANNELS, 4, number of input channels (>=1)
- ARB_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin; selected by generate-if
- CW (localparam), max(1, $clog2(CHANNELS)), channel index width

- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  input  CHANNELS  per-channel beat valid
- in_last  input  CHANNELS  per-channel end-of-packet marker, qualified by in_valid
- in_ready  output  CHANNELS  per-channel accept; at most one bit high
- out_data  output  WIDTH  registered data
- out_last  output  1  registered end-of-packet marker
- out_chan  output  CW  registered index of the source channel
- out_valid  output  1  output register holds a beat
- out_ready  input  1  downstream accept

## Operation

- load_en = !out_valid || out_ready. A beat is accepted from channel i when in_valid[i] && in_ready[i].
- in_ready[i] = load_en && grant[i]. This is combinational from out_ready and in_valid; there is no skid buffer.
- The state machine has two states: IDLE and LOCKED (holds owner[CW-1:0]).
- Grant in IDLE:
  - ARB_MODE=0: lowest-index valid channel.
  - ARB_MODE=1: first valid channel at or after rr_ptr, searching upward modulo CHANNELS.
- Grant in LOCKED: owner only. All other in_ready bits are 0 regardless of their valid.
- Transition IDLE -> LOCKED: a beat is accepted with in_last=0. owner is set to the accepted channel.
- Transition LOCKED -> IDLE: a beat from owner is accepted with in_last=1.
- Single-beat packet in IDLE (accepted with last=1): the block stays IDLE.
- rr_ptr update (ARB_MODE=1 only): on acceptance of a last beat from channel g, rr_ptr <= (g+1) mod CHANNELS. With ARB_MODE=0, rr_ptr is not implemented.
- Owner deasserts in_valid mid-packet: lock is held indefinitely. No other channel is served, and out_valid falls once the register drains.
- Accepted beat: out_data, out_last and out_chan load from the granted channel, and out_valid <= 1.
- No accept with out_ready=1: out_valid <= 0. The data registers hold their value, which is don't-care.
- out_valid=1 with out_ready=0: all output registers are stable.
- CHANNELS=1: ch0 is always granted and out_chan=0. The behaviour is otherwise identical.

## Timing

- Reset values: out_valid=0, out_data=0, out_last=0, out_chan=0, state=IDLE, owner=0, rr_ptr=0.
- in_ready is all-zero during the rst cycle.
- Reset mid-packet drops the lock and discards any beat held in the output register. The source must restart its packet.
- Latency is 1 cycle: a beat accepted at edge k is presented on out_* from edge k onward.
- Throughput is 1 beat/cycle when out_ready is held high.
- Simultaneous out_ready=1 and a new accept: the register reloads in the same edge with no bubble.
- Arbitration is decided per cycle in IDLE only. There is no preemption of a locked packet.

## Test plan

- **Fixed-priority contention.** ARB_MODE=0, CHANNELS=4, WIDTH=8. ch1 and ch3 both send single-beat packets (0x11, 0x33) every cycle, out_ready=1.
  - Required: out_chan=1 and out_data=0x11 on every beat; ch3 never gets in_ready.
- **Round-robin fairness.** ARB_MODE=1. All four channels continuously valid with single-beat packets.
  - Required: out_chan sequence 0,1,2,3,0,1,… with no gaps after the first beat.
- **Packet lock.** ARB_MODE=1. ch2 sends a 3-beat packet (0xA0, 0xA1, 0xA2 with last on the third beat) while ch0 is continuously valid.
  - Required: the 3 beats are contiguous with out_chan=2 and out_last only on 0xA2.
  - Required: ch0 in_ready=0 throughout, and ch0 is granted on the next cycle.
- **Backpressure.** out_ready=0 for 5 cycles while out_valid=1.
  - Required: out_data, out_last and out_chan are stable; all in_ready=0.
  - Required: on out_ready=1, the next beat follows with no bubble.
- **Owner stall.** ch1 is mid-packet and drops in_valid for 4 cycles while ch0 is valid.
  - Required: out_valid falls after the drain and ch0 is not granted.
  - Required: ch1 resumes and completes the packet; ch0 is served after ch1's last beat.
- **Reset mid-packet.** Assert rst for 1 cycle during the second beat of a 4-beat ch3 packet.
  - Required: all outputs are at their reset values the next cycle and state=IDLE.
  - Required: a fresh ch0 beat is accepted immediately after reset deasserts.

Source files
------------

// File: rtl/gen_stream_arb_mux.sv
`default_nettype none
// ============================================================================
// Module   : gen_stream_arb_mux
// Summary  : N-channel valid/ready stream mux with packet locking, fixed-
//            priority or round-robin arbitration and a registered output.
// Revision : 1.0  initial release
// ============================================================================

module gen_stream_arb_mux #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4,
   parameter int ARB_MODE = 0,
   localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   input  logic [CHANNELS-1:0]   in_valid,
   input  logic [CHANNELS-1:0]   in_last,
   output logic [CHANNELS-1:0]   in_ready,
   output logic [WIDTH-1:0]      out_data,
   output logic                  out_last,
   output logic [CW-1:0]         out_chan,
   output logic                  out_valid,
   input  logic                  out_ready
);

   localparam logic [0:0] c_idle   = 1'b0;
   localparam logic [0:0] c_locked = 1'b1;

   logic [0:0]       r_state;
   logic [0:0]       w_state_nxt;
   logic [CW-1:0]    r_owner;
   logic [CW-1:0]    w_owner_nxt;
   logic [CW-1:0]    w_arb_idx;
   logic             w_arb_found;
   logic [CW-1:0]    w_sel;
   logic             w_grant_any;
   logic             w_sel_last;
   logic             w_load_en;
   logic             w_accept;
   logic [WIDTH-1:0] w_chan_data [CHANNELS];
   logic [WIDTH-1:0] r_out_data;
   logic             r_out_last;
   logic [CW-1:0]    r_out_chan;
   logic             r_out_valid;

   for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_unpack
      assign w_chan_data[gi] = in_data[gi*WIDTH +: WIDTH];
   end

   if (ARB_MODE == 1) begin : g_rr
      logic [CW-1:0] r_rr_ptr;

      // Pointer moves past the channel that just finished a packet.
      always_ff @(posedge clk) begin
         if (rst) begin
            r_rr_ptr <= '0;
         end else if (w_accept && w_sel_last) begin
            r_rr_ptr <= CW'((int'(w_sel) + 1) % CHANNELS);
         end
      end

      always_comb begin
         logic [CW-1:0] w_idx;
         w_idx       = '0;
         w_arb_idx   = '0;
         w_arb_found = 1'b0;
         for (int k = 0; k < CHANNELS; k++) begin
            w_idx = CW'((int'(r_rr_ptr) + k) % CHANNELS);
            if (!w_arb_found && in_valid[w_idx]) begin
               w_arb_idx   = w_idx;
               w_arb_found = 1'b1;
            end
         end
      end
   end else begin : g_fixed
      // Scan downward so the lowest valid index is the last one written.
      always_comb begin
         w_arb_idx   = '0;
         w_arb_found = 1'b0;
         for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (in_valid[CW'(k)]) begin
               w_arb_idx   = CW'(k);
               w_arb_found = 1'b1;
            end
         end
      end
   end

   assign w_load_en   = !r_out_valid || out_ready;
   assign w_sel       = (r_state == c_locked) ? r_owner : w_arb_idx;
   assign w_grant_any = (r_state == c_locked) || w_arb_found;
   assign w_sel_last  = in_last[w_sel];
   assign w_accept    = w_load_en && !rst && w_grant_any && in_valid[w_sel];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= c_idle;
         r_owner <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_owner <= w_owner_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_owner_nxt = r_owner;
      case (r_state)
         c_idle: begin
            if (w_accept && !w_sel_last) begin
               w_state_nxt = c_locked;
               w_owner_nxt = w_sel;
            end
         end
         c_locked: begin
            if (w_accept && w_sel_last) begin
               w_state_nxt = c_idle;
            end
         end
         default: w_state_nxt = c_idle;
      endcase
   end

   // A locked owner keeps its grant even while it has no valid beat.
   always_comb begin
      in_ready = '0;
      if (w_load_en && !rst && w_grant_any) begin
         in_ready[w_sel] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_last  <= 1'b0;
         r_out_chan  <= '0;
      end else if (w_accept) begin
         r_out_valid <= 1'b1;
         r_out_data  <= w_chan_data[w_sel];
         r_out_last  <= w_sel_last;
         r_out_chan  <= w_sel;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign out_data  = r_out_data;
   assign out_last  = r_out_last;
   assign out_chan  = r_out_chan;
   assign out_valid = r_out_valid;

endmodule

`default_nettype wire

// File: tb/tb_gen_stream_arb_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_gen_stream_arb_mux
// Summary  : Directed bench for a fixed-priority and a round-robin instance.
// Revision : 1.0  initial release
// ============================================================================

module tb_gen_stream_arb_mux;

   logic        clk = 1'b0;
   logic        rst;

   logic [31:0] fp_in_data, rr_in_data;
   logic [3:0]  fp_in_valid, fp_in_last, fp_in_ready;
   logic [3:0]  rr_in_valid, rr_in_last, rr_in_ready;
   logic [7:0]  fp_out_data, rr_out_data;
   logic        fp_out_last, fp_out_valid, fp_out_ready;
   logic        rr_out_last, rr_out_valid, rr_out_ready;
   logic [1:0]  fp_out_chan, rr_out_chan;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   gen_stream_arb_mux #(.WIDTH(8), .CHANNELS(4), .ARB_MODE(0)) u_fp (
      .clk(clk), .rst(rst),
      .in_data(fp_in_data), .in_valid(fp_in_valid), .in_last(fp_in_last),
      .in_ready(fp_in_ready),
      .out_data(fp_out_data), .out_last(fp_out_last), .out_chan(fp_out_chan),
      .out_valid(fp_out_valid), .out_ready(fp_out_ready)
   );

   gen_stream_arb_mux #(.WIDTH(8), .CHANNELS(4), .ARB_MODE(1)) u_rr (
      .clk(clk), .rst(rst),
      .in_data(rr_in_data), .in_valid(rr_in_valid), .in_last(rr_in_last),
      .in_ready(rr_in_ready),
      .out_data(rr_out_data), .out_last(rr_out_last), .out_chan(rr_out_chan),
      .out_valid(rr_out_valid), .out_ready(rr_out_ready)
   );

   task automatic test_reset();
      rst = 1'b1;
      fp_in_valid = 4'hF; rr_in_valid = 4'hF;
      fp_out_ready = 1'b1; rr_out_ready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      n_checks++;
      if ({fp_in_ready, rr_in_ready} !== 8'h00) begin
         n_fail++; $display("FAIL reset_ready got=%b exp=%b", {fp_in_ready, rr_in_ready}, 8'h00);
      end
      @(posedge clk); #1;
      n_checks++;
      if ({fp_out_valid, fp_out_last, fp_out_chan, fp_out_data} !== 12'h000) begin
         n_fail++; $display("FAIL reset_fp_out got=%h exp=%h", {fp_out_valid, fp_out_last, fp_out_chan, fp_out_data}, 12'h000);
      end
      n_checks++;
      if ({rr_out_valid, rr_out_last, rr_out_chan, rr_out_data} !== 12'h000) begin
         n_fail++; $display("FAIL reset_rr_out got=%h exp=%h", {rr_out_valid, rr_out_last, rr_out_chan, rr_out_data}, 12'h000);
      end
      rst = 1'b0;
      fp_in_valid = 4'h0; rr_in_valid = 4'h0;
   endtask

   task automatic test_fixed_priority();
      fp_in_data = 32'h3300_1100;
      fp_in_valid = 4'b1010; fp_in_last = 4'b1010; fp_out_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         n_checks++;
         if (fp_in_ready !== 4'b0010) begin
            n_fail++; $display("FAIL fp_ready cyc=%0d got=%b exp=%b", c, fp_in_ready, 4'b0010);
         end
         @(posedge clk); #1;
         n_checks++;
         if ({fp_out_valid, fp_out_last, fp_out_chan, fp_out_data} !== {1'b1, 1'b1, 2'd1, 8'h11}) begin
            n_fail++; $display("FAIL fp_out cyc=%0d got=%h exp=%h", c,
                               {fp_out_valid, fp_out_last, fp_out_chan, fp_out_data}, {1'b1, 1'b1, 2'd1, 8'h11});
         end
      end
      fp_in_valid = 4'h0;
   endtask

   task automatic test_round_robin();
      logic [1:0] exp_ch;
      rr_in_data = 32'h4342_4140;
      rr_in_valid = 4'hF; rr_in_last = 4'hF; rr_out_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         exp_ch = 2'(c % 4);
         @(negedge clk);
         n_checks++;
         if (rr_in_ready !== (4'b0001 << exp_ch)) begin
            n_fail++; $display("FAIL rr_ready cyc=%0d got=%b exp=%b", c, rr_in_ready, 4'b0001 << exp_ch);
         end
         @(posedge clk); #1;
         n_checks++;
         if ({rr_out_valid, rr_out_chan, rr_out_data} !== {1'b1, exp_ch, 6'h10, exp_ch}) begin
            n_fail++; $display("FAIL rr_out cyc=%0d got=%h exp=%h", c,
                               {rr_out_valid, rr_out_chan, rr_out_data}, {1'b1, exp_ch, 6'h10, exp_ch});
         end
      end
      rr_in_valid = 4'h0;
      @(posedge clk); #1;
      n_checks++;
      if (rr_out_valid !== 1'b0) begin
         n_fail++; $display("FAIL rr_drain got=%b exp=%b", rr_out_valid, 1'b0);
      end
   endtask

   task automatic test_packet_lock();
      logic [7:0] pk [3];
      pk[0] = 8'hA0; pk[1] = 8'hA1; pk[2] = 8'hA2;
      // Single ch0 beat first moves the pointer to 1 so ch2 wins next.
      rr_in_data = 32'h0000_0005; rr_in_valid = 4'b0001; rr_in_last = 4'b0001;
      @(posedge clk); #1;
      rr_in_data[23:16] = pk[0]; rr_in_valid = 4'b0101; rr_in_last = 4'b0001;
      for (int b = 0; b < 3; b++) begin
         @(negedge clk);
         n_checks++;
         if (rr_in_ready !== 4'b0100) begin
            n_fail++; $display("FAIL lock_ready beat=%0d got=%b exp=%b", b, rr_in_ready, 4'b0100);
         end
         @(posedge clk); #1;
         n_checks++;
         if ({rr_out_valid, rr_out_last, rr_out_chan, rr_out_data} !== {1'b1, (b == 2), 2'd2, pk[b]}) begin
            n_fail++; $display("FAIL lock_out beat=%0d got=%h exp=%h", b,
                               {rr_out_valid, rr_out_last, rr_out_chan, rr_out_data}, {1'b1, (b == 2), 2'd2, pk[b]});
         end
         if (b < 2) begin
            rr_in_data[23:16] = pk[b+1];
            rr_in_last[2] = (b == 1);
         end
      end
      rr_in_valid = 4'b0001;
      @(negedge clk);
      n_checks++;
      if (rr_in_ready !== 4'b0001) begin
         n_fail++; $display("FAIL lock_next_ready got=%b exp=%b", rr_in_ready, 4'b0001);
      end
      @(posedge clk); #1;
      n_checks++;
      if ({rr_out_valid, rr_out_last, rr_out_chan, rr_out_data} !== {1'b1, 1'b1, 2'd0, 8'h05}) begin
         n_fail++; $display("FAIL lock_next_out got=%h exp=%h",
                            {rr_out_valid, rr_out_last, rr_out_chan, rr_out_data}, {1'b1, 1'b1, 2'd0, 8'h05});
      end
      rr_in_valid = 4'h0;
   endtask

   task automatic test_backpressure();
      rr_in_data = 32'h0000_6100; rr_in_valid = 4'b0010; rr_in_last = 4'b0010;
      rr_out_ready = 1'b1;
      @(posedge clk); #1;
      rr_in_data[15:8] = 8'h62;
      rr_out_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         n_checks++;
         if (rr_in_ready !== 4'b0000) begin
            n_fail++; $display("FAIL bp_ready cyc=%0d got=%b exp=%b", c, rr_in_ready, 4'b0000);
         end
         @(posedge clk); #1;
         n_checks++;
         if ({rr_out_valid, rr_out_last, rr_out_chan, rr_out_data} !== {1'b1, 1'b1, 2'd1, 8'h61}) begin
            n_fail++; $display("FAIL bp_hold cyc=%0d got=%h exp=%h", c,
                               {rr_out_valid, rr_out_last, rr_out_chan, rr_out_data}, {1'b1, 1'b1, 2'd1, 8'h61});
         end
      end
      rr_out_ready = 1'b1;
      @(negedge clk);
      n_checks++;
      if (rr_in_ready !== 4'b0010) begin
         n_fail++; $display("FAIL bp_release_ready got=%b exp=%b", rr_in_ready, 4'b0010);
      end
      @(posedge clk); #1;
      n_checks++;
      if ({rr_out_valid, rr_out_chan, rr_out_data} !== {1'b1, 2'd1, 8'h62}) begin
         n_fail++; $display("FAIL bp_release_out got=%h exp=%h", {rr_out_valid, rr_out_chan, rr_out_data}, {1'b1, 2'd1, 8'h62});
      end
      rr_in_valid = 4'h0;
   endtask

   task automatic test_owner_stall();
      rr_in_data = 32'h0000_7100; rr_in_valid = 4'b0010; rr_in_last = 4'b0000;
      @(posedge clk); #1;
      n_checks++;
      if ({rr_out_valid, rr_out_last, rr_out_chan, rr_out_data} !== {1'b1, 1'b0, 2'd1, 8'h71}) begin
         n_fail++; $display("FAIL stall_first got=%h exp=%h",
                            {rr_out_valid, rr_out_last, rr_out_chan, rr_out_data}, {1'b1, 1'b0, 2'd1, 8'h71});
      end
      rr_in_data[7:0] = 8'h0C; rr_in_valid = 4'b0001; rr_in_last = 4'b0001;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         n_checks++;
         if (rr_in_ready[0] !== 1'b0) begin
            n_fail++; $display("FAIL stall_ch0_ready cyc=%0d got=%b exp=%b", c, rr_in_ready[0], 1'b0);
         end
         @(posedge clk); #1;
         n_checks++;
         if (rr_out_valid !== 1'b0) begin
            n_fail++; $display("FAIL stall_drain cyc=%0d got=%b exp=%b", c, rr_out_valid, 1'b0);
         end
      end
      rr_in_data[15:8] = 8'h72; rr_in_valid = 4'b0011; rr_in_last = 4'b0011;
      @(negedge clk);
      n_checks++;
      if (rr_in_ready !== 4'b0010) begin
         n_fail++; $display("FAIL stall_resume_ready got=%b exp=%b", rr_in_ready, 4'b0010);
      end
      @(posedge clk); #1;
      n_checks++;
      if ({rr_out_valid, rr_out_last, rr_out_chan, rr_out_data} !== {1'b1, 1'b1, 2'd1, 8'h72}) begin
         n_fail++; $display("FAIL stall_resume_out got=%h exp=%h",
                            {rr_out_valid, rr_out_last, rr_out_chan, rr_out_data}, {1'b1, 1'b1, 2'd1, 8'h72});
      end
      rr_in_valid = 4'b0001;
      @(posedge clk); #1;
      n_checks++;
      if ({rr_out_valid, rr_out_chan, rr_out_data} !== {1'b1, 2'd0, 8'h0C}) begin
         n_fail++; $display("FAIL stall_ch0_out got=%h exp=%h", {rr_out_valid, rr_out_chan, rr_out_data}, {1'b1, 2'd0, 8'h0C});
      end
      rr_in_valid = 4'h0;
   endtask

   task automatic test_reset_midpacket();
      rr_in_data = 32'hD000_0000; rr_in_valid = 4'b1000; rr_in_last = 4'b0000;
      @(posedge clk); #1;
      n_checks++;
      if ({rr_out_valid, rr_out_chan, rr_out_data} !== {1'b1, 2'd3, 8'hD0}) begin
         n_fail++; $display("FAIL rstmid_first got=%h exp=%h", {rr_out_valid, rr_out_chan, rr_out_data}, {1'b1, 2'd3, 8'hD0});
      end
      rr_in_data[31:24] = 8'hD1;
      rst = 1'b1;
      @(negedge clk);
      n_checks++;
      if (rr_in_ready !== 4'b0000) begin
         n_fail++; $display("FAIL rstmid_ready got=%b exp=%b", rr_in_ready, 4'b0000);
      end
      @(posedge clk); #1;
      n_checks++;
      if ({rr_out_valid, rr_out_last, rr_out_chan, rr_out_data} !== 12'h000) begin
         n_fail++; $display("FAIL rstmid_out got=%h exp=%h", {rr_out_valid, rr_out_last, rr_out_chan, rr_out_data}, 12'h000);
      end
      rst = 1'b0;
      rr_in_data = 32'h0000_00E0; rr_in_valid = 4'b0001; rr_in_last = 4'b0001;
      @(negedge clk);
      n_checks++;
      if (rr_in_ready !== 4'b0001) begin
         n_fail++; $display("FAIL rstmid_fresh_ready got=%b exp=%b", rr_in_ready, 4'b0001);
      end
      @(posedge clk); #1;
      n_checks++;
      if ({rr_out_valid, rr_out_last, rr_out_chan, rr_out_data} !== {1'b1, 1'b1, 2'd0, 8'hE0}) begin
         n_fail++; $display("FAIL rstmid_fresh_out got=%h exp=%h",
                            {rr_out_valid, rr_out_last, rr_out_chan, rr_out_data}, {1'b1, 1'b1, 2'd0, 8'hE0});
      end
      rr_in_valid = 4'h0;
   endtask

   initial begin
      rst = 1'b1;
      fp_in_data = '0; fp_in_valid = '0; fp_in_last = '0; fp_out_ready = 1'b0;
      rr_in_data = '0; rr_in_valid = '0; rr_in_last = '0; rr_out_ready = 1'b0;
      test_reset();
      test_fixed_priority();
      test_round_robin();
      test_packet_lock();
      test_backpressure();
      test_owner_stall();
      test_reset_midpacket();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
